// File: rtl/game_tick_gen.sv
// game_tick_gen: per-channel programmable clock divider producing a
// one-cycle tick and a 50% square wave, with shadowed divisor updates.
module game_tick_gen #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 26,
   parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV =
      {26'd50_000_000, 26'd25_000_000, 26'd16_666_667},
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] enable_i,
   input  logic              pause_i,
   input  logic              cfg_valid_i,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [CNT_W-1:0]  cfg_div_i,
   input  logic              cfg_restart_i,
   output logic              cfg_ready_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] level_o
);

   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
   logic [NUM_CH-1:0][CNT_W-1:0] shd_q, shd_d;
   logic [NUM_CH-1:0]            pend_q, pend_d;
   logic [NUM_CH-1:0]            tick_q, tick_d;
   logic [NUM_CH-1:0]            lvl_q, lvl_d;
   logic                         accept;
   logic                         wr;

   // Only a non-restart write to a channel with a pending shadow stalls.
   always_comb begin
      cfg_ready_o = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch_i == CH_W'(i) && pend_q[i] && !cfg_restart_i) begin
            cfg_ready_o = 1'b0;
         end
      end
   end

   assign accept = cfg_valid_i & cfg_ready_o;

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      lvl_d  = lvl_q;
      tick_d = '0;
      wr     = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr = accept && (cfg_ch_i == CH_W'(i));
         if (wr && cfg_restart_i) begin
            div_d[i]  = cfg_div_i;
            cnt_d[i]  = '0;
            lvl_d[i]  = 1'b0;
            pend_d[i] = 1'b0;
         end else begin
            if (!enable_i[i]) begin
               cnt_d[i] = '0;
               lvl_d[i] = 1'b0;
               if (pend_q[i]) begin
                  div_d[i]  = shd_q[i];
                  pend_d[i] = 1'b0;
               end
            end else if (!pause_i && div_q[i] != '0) begin
               if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                  cnt_d[i]  = '0;
                  tick_d[i] = 1'b1;
                  lvl_d[i]  = ~lvl_q[i];
                  if (pend_q[i]) begin
                     div_d[i]  = shd_q[i];
                     pend_d[i] = 1'b0;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            // A new shadow arms after any wrap on this edge used the old one.
            if (wr) begin
               shd_d[i]  = cfg_div_i;
               pend_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         div_q  <= DEFAULT_DIV;
         shd_q  <= '0;
         pend_q <= '0;
         tick_q <= '0;
         lvl_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         lvl_q  <= lvl_d;
      end
   end

   assign tick_o  = tick_q;
   assign level_o = lvl_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: directed scenarios with literal expectations plus a
// randomized run, all checked against a period-counting reference model.
module tb_game_tick_gen;

   localparam int NCH = 2;
   localparam int CW  = 8;
   localparam logic [NCH*CW-1:0] DEF = {8'd5, 8'd3};

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [NCH-1:0] enable = '0;
   logic           pause = 1'b0;
   logic           cfg_valid = 1'b0;
   logic [1:0]     cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic           cfg_restart = 1'b0;
   logic           cfg_ready;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] level;

   int n_checks = 0;
   int n_fail = 0;

   game_tick_gen #(
      .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF), .CH_W(2)
   ) dut (
      .clk(clk), .reset(reset), .enable_i(enable), .pause_i(pause),
      .cfg_valid_i(cfg_valid), .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div),
      .cfg_restart_i(cfg_restart), .cfg_ready_o(cfg_ready),
      .tick_o(tick), .level_o(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   // Reference model: elapsed cycles in the current period per channel.
   int  m_elapsed [NCH];
   int  m_div     [NCH];
   int  m_shadow  [NCH];
   bit  m_pend    [NCH];
   bit  m_lvl     [NCH];
   bit  m_tick    [NCH];

   function automatic bit model_ready();
      int c = int'(cfg_ch);
      if (c < NCH && m_pend[c] && !cfg_restart) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_elapsed[c] = 0;
            m_div[c]     = int'(DEF[c*CW +: CW]);
            m_shadow[c]  = 0;
            m_pend[c]    = 0;
            m_lvl[c]     = 0;
            m_tick[c]    = 0;
         end
      end else begin
         bit acc;
         acc = cfg_valid && model_ready();
         for (int c = 0; c < NCH; c++) begin
            bit w;
            w = acc && (int'(cfg_ch) == c);
            m_tick[c] = 0;
            if (w && cfg_restart) begin
               m_div[c] = int'(cfg_div);
               m_elapsed[c] = 0;
               m_lvl[c] = 0;
               m_pend[c] = 0;
            end else begin
               if (!enable[c]) begin
                  m_elapsed[c] = 0;
                  m_lvl[c] = 0;
                  if (m_pend[c]) begin
                     m_div[c] = m_shadow[c];
                     m_pend[c] = 0;
                  end
               end else if (!pause && m_div[c] > 0) begin
                  m_elapsed[c] = m_elapsed[c] + 1;
                  if (m_elapsed[c] == m_div[c]) begin
                     m_elapsed[c] = 0;
                     m_tick[c] = 1;
                     m_lvl[c] = !m_lvl[c];
                     if (m_pend[c]) begin
                        m_div[c] = m_shadow[c];
                        m_pend[c] = 0;
                     end
                  end
               end
               if (w) begin
                  m_shadow[c] = int'(cfg_div);
                  m_pend[c] = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("model tick%0d", c), 32'(tick[c]), 32'(m_tick[c]));
         check($sformatf("model level%0d", c), 32'(level[c]), 32'(m_lvl[c]));
      end
      check("model cfg_ready", 32'(cfg_ready), 32'(model_ready()));
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [NCH-1:0] lv;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset tick", 32'(tick), 32'h0);
      check("reset level", 32'(level), 32'h0);
      check("reset cfg_ready", 32'(cfg_ready), 32'h1);

      // Default divisors: ch0 = 3, ch1 = 5.
      enable = 2'b11;
      for (int n = 0; n <= 9; n++) begin
         edge1();
         check("p1 tick0", 32'(tick[0]), 32'(n == 2 || n == 5 || n == 8));
         check("p1 tick1", 32'(tick[1]), 32'(n == 4 || n == 9));
         check("p1 level1", 32'(level[1]), 32'(n >= 4 && n < 9));
      end

      // Shadowed write ch0 <- 2 at cnt = 1, second write stalls.
      cfg_valid = 1; cfg_ch = 0; cfg_div = 8'd2; cfg_restart = 0;
      edge1();
      cfg_div = 8'd7;
      check("shadow stall ready", 32'(cfg_ready), 32'h0);
      check("shadow no tick", 32'(tick[0]), 32'h0);
      edge1();
      check("shadow wrap tick", 32'(tick[0]), 32'h1);
      check("shadow ready back", 32'(cfg_ready), 32'h1);
      cfg_valid = 0;

      // ch1 restart to 4 on the edge where it would have wrapped.
      for (int n = 12; n <= 22; n++) begin
         if (n == 14) begin
            cfg_valid = 1; cfg_ch = 1; cfg_div = 8'd4; cfg_restart = 1;
         end else begin
            cfg_valid = 0; cfg_restart = 0;
         end
         edge1();
         check("new rate tick0", 32'(tick[0]),
               32'(n == 13 || n == 15 || n == 17 || n == 19 || n == 21));
         check("restart tick1", 32'(tick[1]), 32'(n == 18 || n == 22));
         check("restart level1", 32'(level[1]), 32'(n >= 18 && n < 22));
      end
      cfg_valid = 0; cfg_restart = 0;

      // Pause for 7 edges: the ch0 tick due at 23 moves to 30.
      lv = level;
      pause = 1;
      for (int n = 23; n <= 29; n++) begin
         edge1();
         check("pause tick", 32'(tick), 32'h0);
         check("pause level", 32'(level), 32'(lv));
      end
      pause = 0;
      edge1();
      check("post pause tick", 32'(tick), 32'h1);

      // ch0 halted with div 0, ignored out-of-range write, then div 1.
      for (int n = 31; n <= 44; n++) begin
         cfg_valid = (n == 31 || n == 37 || n == 38);
         cfg_restart = 1;
         cfg_ch = (n == 37) ? 2'd3 : 2'd0;
         cfg_div = (n == 31) ? 8'd0 : (n == 37) ? 8'd9 : 8'd1;
         edge1();
         check("div0/1 tick0", 32'(tick[0]), 32'(n >= 39));
         check("div0/1 level0", 32'(level[0]),
               32'(n >= 39 && ((n - 38) % 2 == 1)));
      end

      // Async reset with a pending shadow on ch1.
      cfg_valid = 1; cfg_ch = 1; cfg_div = 8'd7; cfg_restart = 0;
      edge1();
      check("pending before reset", 32'(cfg_ready), 32'h0);
      check("tick before reset", 32'(tick[0]), 32'h1);
      #3 reset = 1'b1;
      #1;
      check("async reset tick", 32'(tick), 32'h0);
      check("async reset level", 32'(level), 32'h0);
      check("async reset ready", 32'(cfg_ready), 32'h1);
      @(posedge clk);
      #1 reset = 1'b0;
      cfg_valid = 0;
      for (int k = 0; k <= 5; k++) begin
         edge1();
         check("resume tick0", 32'(tick[0]), 32'(k == 2 || k == 5));
         check("resume tick1", 32'(tick[1]), 32'(k == 4));
      end

      // Randomized traffic checked by the model.
      for (int n = 0; n < 3000; n++) begin
         enable = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
         pause = ($urandom_range(0, 9) == 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_ch = 2'($urandom);
         cfg_div = 8'($urandom_range(0, 6));
         cfg_restart = ($urandom_range(0, 3) == 0);
         edge1();
      end
      cfg_valid = 0;
      edge1();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
